// File: rtl/rs_syndrome_calc.sv
// RS(255,223) syndrome calculator over GF(2^8), primitive polynomial 0x11D.
// Accepts one received symbol per clock, highest-degree coefficient first, and
// accumulates S_j = r(alpha^(FCR+j)) for j = 0..NSYM-1 with Horner's rule.
// On the last symbol of a frame the packed syndromes are registered into
// synd_out and synd_valid pulses one cycle later.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   din_valid      din carries a symbol this cycle
//   din_sop        first symbol of a frame (qualified by din_valid)
//   din[7:0]       received symbol
//   busy           frame accumulation in progress
//   synd_valid     one-cycle pulse, synd_out/synd_nonzero updated
//   synd_out       packed syndromes, S_j in bits [8j+7:8j]
//   synd_nonzero   any syndrome nonzero
//   frame_err      one-cycle pulse, frame aborted by an early din_sop
//   err_frame_cnt  saturating count of frames with errors
//                  (only when RS_SYND_ERRCNT_EN is defined)
//
// Optional feature macro: RS_SYND_ERRCNT_EN

module rs_syndrome_calc #(
    parameter int unsigned N    = 255,
    parameter int unsigned NSYM = 32,
    parameter int unsigned FCR  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    input  logic                din_sop,
    input  logic [7:0]          din,
    output logic                busy,
    output logic                synd_valid,
    output logic [8*NSYM-1:0]   synd_out,
    output logic                synd_nonzero,
`ifdef RS_SYND_ERRCNT_EN
    output logic [15:0]         err_frame_cnt,
`endif
    output logic                frame_err
);

    localparam int unsigned CntW = $clog2(N + 1);

    // Multiply by alpha (x) modulo 0x11D.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // General GF(2^8) multiply; with a constant operand it reduces to an XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // alpha^(FCR+j) for every lane, evaluated at elaboration.
    function automatic logic [NSYM-1:0][7:0] alpha_table();
        logic [NSYM-1:0][7:0] t;
        logic [7:0]           p;
        p = 8'h01;
        for (int unsigned i = 0; i < (FCR % 255); i++) p = xtime(p);
        for (int unsigned j = 0; j < NSYM; j++) begin
            t[j] = p;
            p    = xtime(p);
        end
        return t;
    endfunction

    localparam logic [NSYM-1:0][7:0] AlphaPow = alpha_table();

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NSYM-1:0][7:0] acc_q, acc_d, acc_upd;
    logic [8*NSYM-1:0]    synd_q;
    logic                 synd_nz_q, synd_valid_q, frame_err_q;
    logic                 sop_take, sym_take, last_sym, early_sop, acc_nz;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (din_valid && din_sop) state_d = StAccum;
            StAccum: if (last_sym)             state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        busy         = (state_q == StAccum);
        synd_valid   = synd_valid_q;
        synd_out     = synd_q;
        synd_nonzero = synd_nz_q;
        frame_err    = frame_err_q;
    end

    // Datapath control and Horner update for all lanes in parallel.
    always_comb begin
        sop_take  = din_valid && din_sop;
        sym_take  = (state_q == StAccum) && din_valid && !din_sop;
        last_sym  = sym_take && (cnt_q == CntW'(N - 1));
        early_sop = (state_q == StAccum) && din_valid && din_sop;

        for (int j = 0; j < NSYM; j++) begin
            acc_upd[j] = gf_mul(acc_q[j], AlphaPow[j]) ^ din;
        end
        acc_nz = |acc_upd;

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (sop_take) begin
            for (int j = 0; j < NSYM; j++) acc_d[j] = din;
            cnt_d = CntW'(1);
        end else if (sym_take) begin
            acc_d = acc_upd;
            cnt_d = last_sym ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            synd_q       <= '0;
            synd_nz_q    <= 1'b0;
            synd_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            synd_valid_q <= last_sym;
            frame_err_q  <= early_sop;
            // Separate output register so a back-to-back frame cannot disturb it.
            if (last_sym) begin
                synd_q    <= acc_upd;
                synd_nz_q <= acc_nz;
            end
        end
    end

`ifdef RS_SYND_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Counted in the same cycle synd_valid is registered, so both appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (last_sym && acc_nz && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_frame_cnt = err_cnt_q;
`endif

endmodule
